// File: rtl/reg_dump_unit.sv
// reg_dump_unit: debug read-out engine for the integer register file.
// Owns one register-file read port while busy and walks [first_reg..last_reg].
// It streams each register over a valid/ready beat interface.
// Optional feature macro: REG_DUMP_CHECKSUM_EN. When it is defined, a trailing
// beat carries the XOR of all dumped words, with idx=0 and last=1.
module reg_dump_unit #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              busy,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_idx,
    output logic              dump_last,
    output logic              done,
    output logic              range_err
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_OUT, S_FIN} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   didx_q, didx_d;
    logic                dlast_q, dlast_d;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0]   csum_q, csum_d;
    logic                csum_beat_q, csum_beat_d;
`endif

    logic hs;
    logic at_last;

    assign dump_valid = (state_q == S_OUT);
    assign hs         = dump_valid & dump_ready;
    // The last register is found by comparison, so idx never has to wrap.
    assign at_last    = (idx_q == last_q);

    assign rf_addr    = (state_q == S_IDLE) ? '0 : idx_q;
    // A rejected range goes straight to FIN and never raises busy.
    assign busy       = (state_q == S_READ) || (state_q == S_OUT) ||
                        ((state_q == S_FIN) && !err_q);
    assign done       = (state_q == S_FIN);
    assign range_err  = (state_q == S_FIN) && err_q;
    assign dump_data  = data_q;
    assign dump_idx   = didx_q;
    assign dump_last  = dlast_q;

    // State and beat registers; reset discards any dump in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
            didx_q  <= '0;
            dlast_q <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_q      <= '0;
            csum_beat_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            err_q   <= err_d;
            data_q  <= data_d;
            didx_q  <= didx_d;
            dlast_q <= dlast_d;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_q      <= csum_d;
            csum_beat_q <= csum_beat_d;
`endif
        end
    end

    // Next-state logic: IDLE -> READ -> OUT (-> READ ...) -> FIN -> IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        err_d   = err_q;
        data_d  = data_q;
        didx_d  = didx_q;
        dlast_d = dlast_q;
`ifdef REG_DUMP_CHECKSUM_EN
        csum_d      = csum_q;
        csum_beat_d = csum_beat_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    last_d = last_reg;
                    idx_d  = first_reg;
`ifdef REG_DUMP_CHECKSUM_EN
                    csum_d      = '0;
                    csum_beat_d = 1'b0;
`endif
                    if (first_reg <= last_reg) begin
                        state_d = S_READ;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end
                end
            end
            S_READ: begin
                data_d = rf_data;
                didx_d = idx_q;
`ifdef REG_DUMP_CHECKSUM_EN
                dlast_d = 1'b0;
                csum_d  = csum_q ^ rf_data;
`else
                dlast_d = at_last;
`endif
                state_d = S_OUT;
            end
            S_OUT: begin
                if (hs) begin
`ifdef REG_DUMP_CHECKSUM_EN
                    if (csum_beat_q) begin
                        state_d = S_FIN;
                    end else if (at_last) begin
                        // Reload the beat registers with the checksum and stay in OUT.
                        data_d      = csum_q;
                        didx_d      = '0;
                        dlast_d     = 1'b1;
                        csum_beat_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_READ;
                    end
`else
                    if (at_last) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_READ;
                    end
`endif
                end
            end
            S_FIN: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides any transition. A beat handshaken in the same cycle still counts as delivered.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            err_d   = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_beat_d = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_reg_dump_unit.sv
// Bench for reg_dump_unit. A behavioural register file and an expected-beat queue model the dump.
module tb_reg_dump_unit;

    logic        clk = 1'b0;
    logic        rst, start, abort, dump_ready;
    logic [4:0]  first_reg, last_reg, rf_addr, dump_idx;
    logic [31:0] rf_data, dump_data;
    logic        busy, dump_valid, dump_last, done, range_err;

    logic [31:0] rfm [32];
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic        last;
    } beat_t;
    beat_t exp_q[$];

    always #5 clk = ~clk;
    assign rf_data = rfm[rf_addr];

    reg_dump_unit #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .first_reg(first_reg), .last_reg(last_reg),
        .abort(abort), .rf_addr(rf_addr), .rf_data(rf_data), .busy(busy),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
        .dump_idx(dump_idx), .dump_last(dump_last), .done(done), .range_err(range_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_expect(input int f, input int l);
        logic [31:0] x;
        exp_q.delete();
        x = '0;
        if (f <= l) begin
            for (int i = f; i <= l; i++) begin
                beat_t b;
                b.idx = i; b.data = rfm[i]; b.last = (i == l);
                x ^= rfm[i];
`ifdef REG_DUMP_CHECKSUM_EN
                b.last = 1'b0;
`endif
                exp_q.push_back(b);
            end
`ifdef REG_DUMP_CHECKSUM_EN
            begin
                beat_t cb;
                cb.idx = 0; cb.data = x; cb.last = 1'b1;
                exp_q.push_back(cb);
            end
`endif
        end
    endtask

    // mode: 1 ready held high, 2 random ready, 3 ready toggling. kill_kind: 1 abort, 2 reset.
    task automatic do_dump(input int f, input int l, input int mode, input int kill_at, input int kill_kind);
        int c, nb;
        bit done_seen, pv, pr;
        logic [31:0] pd;
        logic [4:0]  pi;
        logic        pl;
        build_expect(f, l);
        start = 1'b1; first_reg = f[4:0]; last_reg = l[4:0];
        @(posedge clk); #1;
        start = 1'b0;
        c = 1; nb = 0; done_seen = 0; pv = 0; pr = 0; pd = '0; pi = '0; pl = 0;
        while (!done_seen && c < 200) begin
            case (mode)
                1:       dump_ready = 1'b1;
                2:       dump_ready = 1'($urandom_range(0, 1));
                default: dump_ready = ((c % 2) == 0);
            endcase
            if (c == kill_at) begin
                if (kill_kind == 1) abort = 1'b1; else rst = 1'b0;
            end
            @(negedge clk);
            chk("busy_run", busy, (f <= l));
            if (pv && !pr) begin
                chk("hold_valid", dump_valid, 1'b1);
                chk("hold_data", dump_data, pd);
                chk("hold_idx", dump_idx, pi);
                chk("hold_last", dump_last, pl);
            end
            if (dump_valid && dump_ready) begin
                if (nb < exp_q.size()) begin
                    chk("beat_idx", dump_idx, exp_q[nb].idx);
                    chk("beat_data", dump_data, exp_q[nb].data);
                    chk("beat_last", dump_last, exp_q[nb].last);
                end else begin
                    chk("extra_beat", nb, exp_q.size());
                end
                if (mode == 1) chk("beat_cycle", c, 2 + 2 * nb);
                nb++;
            end
            if (done) begin
                done_seen = 1;
                chk("range_err", range_err, (f > l));
                if (mode == 1) chk("done_cycle", c, 2 * exp_q.size() + 1);
            end
            pv = dump_valid; pr = dump_ready; pd = dump_data; pi = dump_idx; pl = dump_last;
            @(posedge clk); #1;
            if (c == kill_at) begin
                abort = 1'b0; rst = 1'b1;
                break;
            end
            c++;
        end
        dump_ready = 1'b0;
        if (kill_at > 0) begin
            chk("kill_beats", nb, kill_at / 2);
            chk("kill_no_done", done_seen, 1'b0);
            @(negedge clk);
            chk("kill_valid", dump_valid, 1'b0);
            chk("kill_busy", busy, 1'b0);
            chk("kill_done", done, 1'b0);
            if (kill_kind == 2) begin
                chk("rst_data", dump_data, 32'h0);
                chk("rst_idx", dump_idx, 5'h0);
                chk("rst_last", dump_last, 1'b0);
                chk("rst_addr", rf_addr, 5'h0);
                chk("rst_rerr", range_err, 1'b0);
            end
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("kill_late_done", done, 1'b0);
            end
            @(posedge clk); #1;
        end else begin
            chk("done_seen", done_seen, 1'b1);
            chk("beat_count", nb, exp_q.size());
            @(negedge clk);
            chk("busy_after", busy, 1'b0);
            chk("done_after", done, 1'b0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; dump_ready = 1'b0;
        first_reg = '0; last_reg = '0;
        rfm[0] = '0;
        for (int i = 1; i < 32; i++) rfm[i] = $urandom;
        rfm[1] = 32'h11; rfm[2] = 32'h22; rfm[3] = 32'h33; rfm[31] = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_valid", dump_valid, 1'b0);
        chk("reset_data", dump_data, 32'h0);
        chk("reset_idx", dump_idx, 5'h0);
        chk("reset_last", dump_last, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_rerr", range_err, 1'b0);
        chk("reset_addr", rf_addr, 5'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        do_dump(1, 3, 1, 0, 0);     // directed x1..x3, ready held high
        do_dump(1, 3, 3, 0, 0);     // same with ready toggling
        do_dump(5, 2, 1, 0, 0);     // rejected range
        do_dump(31, 31, 1, 0, 0);   // single top register
        do_dump(0, 0, 1, 0, 0);     // x0 alone
        do_dump(0, 31, 1, 20, 1);   // abort on 10th beat's OUT cycle
        do_dump(4, 9, 1, 0, 0);     // restart after abort
        do_dump(0, 31, 1, 15, 2);   // reset mid-dump
        do_dump(2, 6, 1, 0, 0);     // restart after reset
        for (int t = 0; t < 6; t++) begin
            int f, l;
            f = $urandom_range(0, 31);
            l = $urandom_range(0, 31);
            do_dump(f, l, 2, 0, 0);
        end
        // Abort in IDLE must have no effect.
        abort = 1'b1;
        @(negedge clk);
        chk("idle_abort_busy", busy, 1'b0);
        @(posedge clk); #1;
        abort = 1'b0;
        do_dump(0, 31, 2, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_dump_unit.md
Name: reg_dump_unit

Overview:
- Debug read-out engine for the integer register file; the reading counterpart to the writeback path that fills it.
- On a start request it takes ownership of one register-file read port and walks an address range in order. Each register's contents is streamed out over a valid/ready beat interface to the debug/trace logic.
- Sits beside the decode stage. While busy is high, the top level muxes rf_addr onto the register file's first read-address input.

Parameters:
- ADDR_W, 5, register index width.
- DATA_W, 32, register data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-low reset.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- first_reg  input  ADDR_W  first register index; sampled with start.
- last_reg  input  ADDR_W  last register index, inclusive; sampled with start.
- abort  input  1  synchronous cancel of a dump in progress.
- rf_addr  output  ADDR_W  read address driven to the register file.
- rf_data  input  DATA_W  combinational read data returned from the register file.
- busy  output  1  high from the cycle after an accepted start until return to IDLE.
- dump_valid  output  1  beat valid.
- dump_ready  input  1  consumer ready.
- dump_data  output  DATA_W  register contents for the current beat.
- dump_idx  output  ADDR_W  register index of the current beat.
- dump_last  output  1  high on the final beat.
- done  output  1  one-cycle pulse after the final beat is accepted, or after a rejected range.
- range_err  output  1  one-cycle pulse, coincident with done, when first_reg > last_reg.

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE; index and data registers cleared. Outputs: busy=0, dump_valid=0, dump_data=0, dump_idx=0, dump_last=0, done=0, range_err=0, rf_addr=0.
- Reset takes priority over abort and start. Reset mid-dump discards the dump silently, with no done pulse.
- States: IDLE, READ, OUT, FIN.
- IDLE:
  - start=1 with first_reg<=last_reg: latch the range, idx<=first_reg, go READ.
  - start=1 with first_reg>last_reg: go FIN with err flag set; no beats are produced.
- READ: rf_addr=idx. Capture dump_data<=rf_data and dump_idx<=idx. Set dump_last<=(idx==last). Go OUT.
- OUT:
  - dump_valid=1. dump_data, dump_idx and dump_last are held stable until dump_valid&dump_ready.
  - On handshake with not last: idx<=idx+1, go READ.
  - On handshake with last: go FIN.
- FIN: done=1 (range_err=1 if err flag set), clear err, go IDLE. Lasts exactly one cycle.
- rf_addr = idx in every state except IDLE, where it is 0.
- Throughput: 2 cycles per beat when dump_ready is held high. First beat has dump_valid high 2 cycles after the start cycle.
- idx arithmetic is ADDR_W-bit. last_reg=31 ends via the last compare, so idx never wraps.
- first_reg==last_reg produces exactly one beat, with dump_last=1.
- start while not in IDLE is ignored.
- abort=1 in READ/OUT/FIN: next state IDLE, dump_valid drops next cycle, no done. abort in IDLE has no effect.
- abort and a handshake in the same cycle: abort wins, and the beat counts as delivered.
- Register x0 is dumped like any other index; it reads 0 from the register file.

Optional Feature:
- Macro: REG_DUMP_CHECKSUM_EN.
- Defined:
  - A running XOR of every dumped word is kept, cleared on start.
  - After the final register beat is accepted, one extra OUT beat carries the checksum: dump_idx=0 and dump_last=1.
  - In this mode dump_last is 0 on the final register beat. done follows acceptance of the checksum beat.
  - A range error produces no checksum beat.
- Undefined: no checksum logic; behaviour exactly as above.

Test Plan:
- Regs x1..x3 = 0x11, 0x22, 0x33; start with first=1, last=3; ready=1 -> three beats (1,0x11), (2,0x22), (3,0x33) on cycles t+2, t+4, t+6; dump_last only on idx 3; done at t+7; busy low at t+8.
- Same dump, ready toggled 0/1 every cycle -> data and idx held stable while ready=0, no beat lost or duplicated, same three beats.
- first=5, last=2 -> zero beats; done=1 and range_err=1 at t+1; busy stays 0.
- first=last=31, x31=0xDEADBEEF -> single beat (31, 0xDEADBEEF) with dump_last=1; done follows; no index wrap.
- Full dump 0..31, abort asserted on the 10th beat's OUT cycle -> dump_valid low next cycle, no done; a new start then works normally. Repeat with rst=0 mid-dump -> all outputs 0.
- With REG_DUMP_CHECKSUM_EN, dump 1..3 of 0x11, 0x22, 0x33 -> fourth beat with data 0x00, idx 0, dump_last=1; dump_last=0 on the idx 3 beat.
